// File: rtl/pyjamask96_pkg.sv
// rtl/pyjamask96_pkg.sv - Pyjamask-96 constants and GF(2) circulant helpers shared by encryptor and decryptor
package pyjamask96_pkg;

   typedef logic [31:0] word_t;

   localparam int NB_ROUNDS_96 = 14;
   localparam int ROUND_W      = 5;

   localparam word_t COL_M0 = 32'ha3861085;
   localparam word_t COL_M1 = 32'h63417021;
   localparam word_t COL_M2 = 32'h692cf280;
   localparam word_t COL_MK = 32'hb881b9ca;

   localparam int ROT1 = 8;
   localparam int ROT2 = 15;
   localparam int ROT3 = 18;

   localparam word_t KS_C0 = 32'h00000080;
   localparam word_t KS_C1 = 32'h00006a00;
   localparam word_t KS_C2 = 32'h003f0000;
   localparam word_t KS_C3 = 32'h24000000;

   function automatic word_t rotl32(input word_t x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // column j of the circulant is col rotated right by j; vec bit 31 selects column 0
   function automatic word_t mat_mult(input word_t col, input word_t vec);
      word_t res;
      word_t c;
      res = '0;
      c   = col;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) res = res ^ c;
         c = {c[0], c[31:1]};
      end
      return res;
   endfunction

   // every invertible 32x32 GF(2) circulant satisfies C^32 = I, so C^-1 = C^31
   function automatic word_t circ_inv_col(input word_t col);
      word_t acc;
      acc = col;
      for (int k = 0; k < 30; k++) acc = mat_mult(col, acc);
      return acc;
   endfunction

   localparam word_t COL_INV_M0 = circ_inv_col(COL_M0);
   localparam word_t COL_INV_M1 = circ_inv_col(COL_M1);
   localparam word_t COL_INV_M2 = circ_inv_col(COL_M2);
   localparam word_t COL_INV_MK = circ_inv_col(COL_MK);

endpackage

// File: rtl/pyjamask96_key_step.sv
// rtl/pyjamask96_key_step.sv - one Pyjamask-96 key schedule step, forward or backward
module pyjamask96_key_step
   import pyjamask96_pkg::*;
(
   input  logic               backward,
   input  logic [ROUND_W-1:0] round,
   input  logic [127:0]       key_in,
   output logic [127:0]       key_out
);

   word_t k0, k1, k2, k3, rc0;
   word_t fmix, f0, f1, f2, f3;
   word_t bmix, b0, b1, b2, b3;

   always_comb begin
      k0  = key_in[127:96];
      k1  = key_in[95:64];
      k2  = key_in[63:32];
      k3  = key_in[31:0];
      rc0 = KS_C0 ^ {{(32-ROUND_W){1'b0}}, round};

      fmix = k0 ^ k1 ^ k2 ^ k3;
      f0   = mat_mult(COL_MK, k0 ^ fmix) ^ rc0;
      f1   = rotl32(k1 ^ fmix, ROT1) ^ KS_C1;
      f2   = rotl32(k2 ^ fmix, ROT2) ^ KS_C2;
      f3   = rotl32(k3 ^ fmix, ROT3) ^ KS_C3;

      // column mixing is its own inverse, so it closes the backward step unchanged
      b0   = mat_mult(COL_INV_MK, k0 ^ rc0);
      b1   = rotl32(k1 ^ KS_C1, 32 - ROT1);
      b2   = rotl32(k2 ^ KS_C2, 32 - ROT2);
      b3   = rotl32(k3 ^ KS_C3, 32 - ROT3);
      bmix = b0 ^ b1 ^ b2 ^ b3;

      key_out = backward ? {b0 ^ bmix, b1 ^ bmix, b2 ^ bmix, b3 ^ bmix}
                         : {f0, f1, f2, f3};
   end

endmodule

// File: rtl/pyjamask96_dec.sv
// rtl/pyjamask96_dec.sv - byte-serial Pyjamask-96 decryptor, one round phase per cycle
module pyjamask96_dec
   import pyjamask96_pkg::*;
#(
   parameter int NB_ROUNDS = NB_ROUNDS_96
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic [7:0] byte_key_in,
   output logic       busy,
   output logic       valid,
   output logic [7:0] byte_out
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] LOAD    = 4'd1;
   localparam logic [3:0] LOADED  = 4'd2;
   localparam logic [3:0] KEY_FWD = 4'd3;
   localparam logic [3:0] WHITEN  = 4'd4;
   localparam logic [3:0] INV_MIX = 4'd5;
   localparam logic [3:0] INV_SUB = 4'd6;
   localparam logic [3:0] ADD_KEY = 4'd7;
   localparam logic [3:0] OUT     = 4'd8;

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NB_ROUNDS - 1);

   logic [3:0]         st;
   logic [95:0]        state_q;
   logic [127:0]       key_q;
   logic [ROUND_W-1:0] round_q;
   logic [3:0]         cnt_q;
   logic [127:0]       key_next;
   logic [95:0]        mix_out;
   logic [95:0]        sub_out;
   word_t              a, b, c;

   pyjamask96_key_step u_key_step (
      .backward (st != KEY_FWD),
      .round    (round_q),
      .key_in   (key_q),
      .key_out  (key_next)
   );

   always_comb begin
      mix_out = {mat_mult(COL_INV_M0, state_q[95:64]),
                 mat_mult(COL_INV_M1, state_q[63:32]),
                 mat_mult(COL_INV_M2, state_q[31:0])};
      // a/b/c start as s1/s0/~s2: the row swap and inversion come first
      a = state_q[63:32];
      b = state_q[95:64];
      c = ~state_q[31:0];
      a = a ^ b;
      c = c ^ a;
      b = b ^ (a & c);
      a = a ^ (b & c);
      c = c ^ (a & b);
      b = b ^ c;
      a = a ^ b;
      sub_out = {a, b, c};
   end

   always_comb begin
      busy = st inside {KEY_FWD, WHITEN, INV_MIX, INV_SUB, ADD_KEY, OUT};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= IDLE;
         state_q  <= '0;
         key_q    <= '0;
         round_q  <= '0;
         cnt_q    <= '0;
         valid    <= 1'b0;
         byte_out <= 8'h00;
      end else begin
         valid    <= 1'b0;
         byte_out <= 8'h00;
         case (st)
            IDLE, LOADED: begin
               if (load) begin
                  key_q   <= {key_q[119:0], byte_key_in};
                  state_q <= {state_q[87:0], byte_in};
                  cnt_q   <= 4'd1;
                  st      <= LOAD;
               end else if (st == LOADED && start) begin
                  round_q <= '0;
                  st      <= KEY_FWD;
               end
            end
            LOAD: begin
               if (load) begin
                  key_q <= {key_q[119:0], byte_key_in};
                  if (cnt_q < 4'd12) state_q <= {state_q[87:0], byte_in};
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) st <= LOADED;
               end
            end
            KEY_FWD: begin
               key_q   <= key_next;
               round_q <= round_q + ROUND_W'(1);
               if (round_q == LAST_ROUND) st <= WHITEN;
            end
            WHITEN: begin
               state_q <= state_q ^ key_q[127:32];
               round_q <= LAST_ROUND;
               st      <= INV_MIX;
            end
            INV_MIX: begin
               state_q <= mix_out;
               st      <= INV_SUB;
            end
            INV_SUB: begin
               state_q <= sub_out;
               key_q   <= key_next;
               st      <= ADD_KEY;
            end
            ADD_KEY: begin
               state_q <= state_q ^ key_q[127:32];
               if (round_q == '0) begin
                  cnt_q <= '0;
                  st    <= OUT;
               end else begin
                  round_q <= round_q - ROUND_W'(1);
                  st      <= INV_MIX;
               end
            end
            OUT: begin
               if (cnt_q == 4'd12) begin
                  st <= IDLE;
               end else begin
                  valid    <= 1'b1;
                  byte_out <= state_q[95:88];
                  state_q  <= state_q << 8;
                  cnt_q    <= cnt_q + 4'd1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pyjamask96_dec.sv
// tb/tb_pyjamask96_dec.sv - self-checking bench for pyjamask96_dec against a round-trip cipher model
module tb_pyjamask96_dec;
   import pyjamask96_pkg::*;

   logic       clk = 1'b0;
   logic       reset, load, start;
   logic [7:0] byte_in, byte_key_in;
   logic       busy, valid;
   logic [7:0] byte_out;

   pyjamask96_dec dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .start       (start),
      .byte_in     (byte_in),
      .byte_key_in (byte_key_in),
      .busy        (busy),
      .valid       (valid),
      .byte_out    (byte_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          chk_en   = 1'b0;
   int          start_cyc = -1;
   int          end_cyc   = 0;
   logic [95:0] exp_pt = '0;
   int          nvalid = 0;
   int          first_valid = 0;
   logic [95:0] got_pt = '0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
   endtask

   // reference cipher: matrix applied row by row as dot products
   function automatic logic [31:0] m_mul(input logic [31:0] col, input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         logic acc;
         acc = 1'b0;
         for (int j = 0; j < 32; j++) acc = acc ^ (col[(31 - i + j) % 32] & v[31 - j]);
         r[31 - i] = acc;
      end
      return r;
   endfunction

   function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} << n;
      return d[63:32];
   endfunction

   function automatic logic [95:0] m_sbox(input logic [95:0] s);
      logic [31:0] s0, s1, s2;
      {s0, s1, s2} = s;
      s0 ^= s1;
      s1 ^= s2;
      s2 ^= s0 & s1;
      s0 ^= s1 & s2;
      s1 ^= s0 & s2;
      s2 ^= s0;
      s0 ^= s1;
      s2 = ~s2;
      return {s1, s0, s2};
   endfunction

   function automatic logic [127:0] m_ks_next(input logic [127:0] k, input int r);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t = w0 ^ w1 ^ w2 ^ w3;
      w0 = m_mul(COL_MK, w0 ^ t) ^ 32'h00000080 ^ 32'(r);
      w1 = m_rotl(w1 ^ t, 8)  ^ 32'h00006a00;
      w2 = m_rotl(w2 ^ t, 15) ^ 32'h003f0000;
      w3 = m_rotl(w3 ^ t, 18) ^ 32'h24000000;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [95:0] m_enc(input logic [95:0] pt, input logic [127:0] key);
      logic [95:0]  s;
      logic [127:0] k;
      s = pt;
      k = key;
      for (int r = 0; r < 14; r++) begin
         s = m_sbox(s ^ k[127:32]);
         s = {m_mul(COL_M0, s[95:64]), m_mul(COL_M1, s[63:32]), m_mul(COL_M2, s[31:0])};
         k = m_ks_next(k, r);
      end
      return s ^ k[127:32];
   endfunction

   function automatic bit circ_ok(input logic [31:0] col, input logic [31:0] inv);
      logic [31:0] e;
      for (int j = 0; j < 32; j++) begin
         e = 32'h1 << j;
         if (m_mul(col, m_mul(inv, e)) !== e) return 1'b0;
         if (m_mul(inv, m_mul(col, e)) !== e) return 1'b0;
      end
      return 1'b1;
   endfunction

   // cycle-accurate expectation: busy for 70 cycles from the start edge, bytes at +58..+69
   always @(negedge clk) begin
      int d;
      logic       eb, ev;
      logic [7:0] ebyte;
      if (chk_en) begin
         d = cyc - start_cyc;
         eb = 1'b0;
         ev = 1'b0;
         ebyte = 8'h00;
         if (start_cyc >= 0 && cyc < end_cyc && d >= 0 && d < 70) begin
            eb = 1'b1;
            if (d >= 58) begin
               ev = 1'b1;
               ebyte = exp_pt[95 - 8*(d - 58) -: 8];
            end
         end
         check("busy", busy, eb);
         check("valid", valid, ev);
         check("byte_out", byte_out, ebyte);
      end
   end

   always @(negedge clk) begin
      if (chk_en && valid === 1'b1) begin
         if (nvalid == 0) first_valid = cyc;
         got_pt = {got_pt[87:0], byte_out};
         nvalid++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      end_cyc = cyc + 1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic load_bytes(input logic [95:0] ct, input logic [127:0] key, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         load = 1'b1;
         byte_key_in = key[127 - 8*i -: 8];
         if (i < 12) byte_in = ct[95 - 8*i -: 8];
         else        byte_in = 8'($urandom);
         tick(1);
      end
      load = 1'b0;
      byte_in = 8'h00;
      byte_key_in = 8'h00;
   endtask

   task automatic pulse_start(input bit accept, input logic [95:0] pt);
      start = 1'b1;
      if (accept) begin
         start_cyc = cyc + 1;
         end_cyc = 1 << 30;
         exp_pt = pt;
         nvalid = 0;
      end
      tick(1);
      start = 1'b0;
   endtask

   task automatic finish_txn(input string tag, input logic [95:0] pt);
      check({tag, "_nbytes"}, 128'(nvalid), 128'd12);
      check({tag, "_latency"}, 128'(first_valid - start_cyc), 128'd58);
      check({tag, "_plaintext"}, got_pt, pt);
   endtask

   task automatic run_pair(input string tag, input logic [95:0] pt, input logic [127:0] key);
      load_bytes(m_enc(pt, key), key, 0, 15);
      pulse_start(1'b1, pt);
      tick(70);
      finish_txn(tag, pt);
   endtask

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [95:0]  PT_A  = 96'h000102030405060708090a0b;
   localparam logic [127:0] KEY_B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [95:0]  PT_B  = 96'hfedcba9876543210deadbeef;
   localparam logic [127:0] KEY_C = {128{1'b1}};
   localparam logic [95:0]  PT_C  = 96'h0;
   localparam logic [127:0] KEY_D = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [95:0]  PT_D  = 96'h6bc1bee22e409f96e93d7e11;
   localparam logic [127:0] KEY_E = 128'h0;
   localparam logic [95:0]  PT_E  = {96{1'b1}};

   initial begin
      reset = 1'b1;
      load = 1'b1;
      start = 1'b1;
      byte_in = 8'ha5;
      byte_key_in = 8'h5a;
      tick(2);
      reset = 1'b0;
      load = 1'b0;
      start = 1'b0;
      check("reset_busy", busy, 1'b0);
      check("reset_valid", valid, 1'b0);
      check("reset_byte_out", byte_out, 8'h00);
      chk_en = 1'b1;

      check("model_sbox_zero", m_sbox(96'h0), {32'h0, 32'h0, 32'hffffffff});
      check("model_sbox_s0", m_sbox({32'hffffffff, 64'h0}), {32'h0, 32'hffffffff, 32'h0});
      check("model_mul_msb", m_mul(32'ha3861085, 32'h80000000), 32'ha3861085);
      check("model_mul_lsb", m_mul(32'ha3861085, 32'h00000001), 32'h470c210b);
      check("model_ks_zero", m_ks_next(128'h0, 0), 128'h00000080_00006a00_003f0000_24000000);
      check("inv_M0", circ_ok(COL_M0, COL_INV_M0), 1'b1);
      check("inv_M1", circ_ok(COL_M1, COL_INV_M1), 1'b1);
      check("inv_M2", circ_ok(COL_M2, COL_INV_M2), 1'b1);
      check("inv_MK", circ_ok(COL_MK, COL_INV_MK), 1'b1);

      // start with nothing loaded
      pulse_start(1'b0, '0);
      tick(5);
      check("idle_start_no_valid", 128'(nvalid), 128'd0);

      // round trip with a load gap before start
      load_bytes(m_enc(PT_A, KEY_A), KEY_A, 0, 15);
      tick(2);
      pulse_start(1'b1, PT_A);
      tick(70);
      finish_txn("rt_a", PT_A);
      check("rt_a_literal", got_pt, 96'h000102030405060708090a0b);

      // start after 10 bytes is ignored; the count survives the gap
      load_bytes(m_enc(PT_B, KEY_B), KEY_B, 0, 9);
      pulse_start(1'b0, '0);
      tick(3);
      check("short_load_no_busy", busy, 1'b0);
      load_bytes(m_enc(PT_B, KEY_B), KEY_B, 10, 15);
      pulse_start(1'b1, PT_B);
      tick(70);
      finish_txn("rt_b", PT_B);

      // load and start while busy are ignored
      load_bytes(m_enc(PT_C, KEY_C), KEY_C, 0, 15);
      pulse_start(1'b1, PT_C);
      load_bytes({3{32'hdeadbeef}}, {4{32'hcafef00d}}, 0, 15);
      pulse_start(1'b0, '0);
      tick(53);
      finish_txn("busy_abuse", PT_C);
      nvalid = 0;
      pulse_start(1'b0, '0);
      tick(5);
      check("post_abuse_idle_start", 128'(nvalid), 128'd0);

      // reset during round 7, then a fresh operation
      load_bytes(m_enc(PT_D, KEY_D), KEY_D, 0, 15);
      pulse_start(1'b1, PT_D);
      tick(34);
      do_reset();
      check("mid_reset_busy", busy, 1'b0);
      check("mid_reset_valid", valid, 1'b0);
      tick(30);
      check("mid_reset_no_valid", 128'(nvalid), 128'd0);
      run_pair("after_reset", PT_D, KEY_D);

      // back to back: next load starts the cycle busy falls
      run_pair("b2b_first", PT_E, KEY_E);
      run_pair("b2b_second", PT_B, KEY_A);

      tick(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pyjamask96_dec.md
PYJAMASK96_DEC -- requirements
Module: pyjamask96_dec

Interface
REQ-001 SHALL have parameter NB_ROUNDS, default 14, number of Pyjamask-96 rounds.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  byte-load strobe for ciphertext and key.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins decryption.
REQ-006 SHALL have port byte_in  input  8  ciphertext byte, most significant byte first.
REQ-007 SHALL have port byte_key_in  input  8  key byte, most significant byte first.
REQ-008 SHALL have port busy  output  1  high from accepted start until the last output byte.
REQ-009 SHALL have port valid  output  1  qualifies byte_out.
REQ-010 SHALL have port byte_out  output  8  plaintext byte, most significant byte first.

Function
REQ-011 SHALL use the FSM states IDLE, LOAD, LOADED, KEY_FWD, WHITEN, INV_MIX, INV_SUB, ADD_KEY and OUT.
REQ-012 SHALL move from IDLE to LOAD on load=1 and capture the first bytes in that cycle.
REQ-013 SHALL shift in one key byte on every load=1 cycle, and one ciphertext byte on each of the first 12 of those cycles.
REQ-014 SHALL enter LOADED after the 16th key byte; a load gap before then holds the byte count (no abort).
REQ-015 SHALL ignore start in any state other than LOADED, and SHALL restart loading at byte 0 on load=1 in LOADED.
REQ-016 SHALL run KEY_FWD for NB_ROUNDS cycles after start; step r (0..13) computes rk(r+1) from rk(r) as: MixColumns, then MixAndRotateRows (row0 by circulant MK 0xb881b9ca; rows 1/2/3 rotated 8/15/18), then AddConstant (0x00000080^r, 0x00006a00, 0x003f0000, 0x24000000).
REQ-017 SHALL, in WHITEN, perform state ^= rk14[0:95].
REQ-018 SHALL, for r = 13 down to 0, execute INV_MIX, then INV_SUB, then ADD_KEY, one cycle each.
REQ-019 SHALL, in INV_MIX, multiply row i by the GF(2) inverse of the circulant with column M0=0xa3861085, M1=0x63417021 or M2=0x692cf280 respectively.
REQ-020 SHALL, in INV_SUB, apply this sequence to rows s0,s1,s2: swap s0/s1; s2=~s2; s0^=s1; s2^=s0; s1^=s0&s2; s0^=s1&s2; s2^=s0&s1; s1^=s2; s0^=s1.
REQ-021 SHALL, in INV_MIX and INV_SUB of round r, step the key backward from rk(r+1) to rk(r): inverse AddConstant with r; inverse rotations 8/15/18; inverse-MK on row0; MixColumns, which is an involution.
REQ-022 SHALL, in ADD_KEY, perform state ^= rk(r)[0:95].
REQ-023 SHALL take 58 cycles from the start-sampling edge to the first valid, with NB_ROUNDS=14.
REQ-024 SHALL, in OUT, hold valid=1 for exactly 12 consecutive cycles carrying state bytes 0..11, then return to IDLE with busy=0.
REQ-025 SHALL ignore load and start while busy=1.
REQ-026 SHALL hold byte_out at 0 whenever valid=0.

Reset
REQ-027 SHALL, on reset=1 (including mid-operation), go to IDLE with busy=0, valid=0 and byte_out=0, clearing the state register, key register, round counter and byte counter.
REQ-028 SHALL let reset override load and start in the same cycle.

Structure
REQ-029 SHALL place NB_ROUNDS_96, the M0/M1/M2/MK columns, the inverse columns, the rotation amounts and the key constants in a shared package pyjamask96_pkg, used by both the encryptor and the decryptor.
REQ-030 SHALL place the forward and backward key step in one sub-module, pyjamask96_key_step, with a direction input.
REQ-031 SHALL define each inverse column as the first column of the GF(2) inverse of its circulant, computed offline.

Verification
REQ-032 SHALL cover round-trip: key 0x000102..0f and plaintext 0x000102..0b are encrypted by pyjamask96, the ciphertext is fed to this block, and the output equals 0x000102..0b.
REQ-033 SHALL cover matrix check: for each of M0/M1/M2/MK, the circulant times its inverse-column circulant equals the identity.
REQ-034 SHALL cover latency: start at cycle T gives the first valid at T+58, valid high for T+58..T+69, and busy low from T+70.
REQ-035 SHALL cover reset during round 7: no valid is produced, outputs are 0 next cycle, and a fresh load then returns the correct plaintext.
REQ-036 SHALL cover protocol abuse: start in IDLE, start after only 10 load bytes, and load while busy produce no change and no valid.
REQ-037 SHALL cover back-to-back operation: a second load/start directly after the first completes returns a correct second plaintext.
